fx_mul_arbiter: RTL and testbench
=================================

# fx_mul_arbiter

Round-robin arbiter that shares one pipelined fixed-point multiplier, with valid/ready on both sides, among NREQ requesters, such as the per-path regression and discounting stages of the LSM pipeline. It issues at most one operand pair per cycle and records the requester index of each issued operation in an in-order tag FIFO. It steers each multiplier result back to the requester that issued it. The block contains no arithmetic; it only sequences and routes.

## Interface
- WIDTH, fpga_cfg_pkg::FP_WIDTH: operand/result width (signed fixed point; the format is opaque here).
- NREQ, 4: number of requesters, ≥2.
- MAX_INFLIGHT, 8: tag FIFO depth and the maximum number of issued-but-unreturned operations; power of two, ≥2.
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- req_valid, in, NREQ: per-requester operand-pair valid.
- req_ready, out, NREQ: per-requester accept; one-hot or zero.
- req_a, in, NREQ×WIDTH: operand a per requester.
- req_b, in, NREQ×WIDTH: operand b per requester.
- rsp_valid, out, NREQ: per-requester result valid; one-hot or zero.
- rsp_ready, in, NREQ: per-requester result accept.
- rsp_result, out, WIDTH: result, shared by all requesters, qualified by rsp_valid.
- mul_valid_in, out, 1: operand valid to the multiplier.
- mul_ready_out, in, 1: multiplier can accept.
- mul_a, out, WIDTH: operand a to the multiplier.
- mul_b, out, WIDTH: operand b to the multiplier.
- mul_valid_out, in, 1: multiplier result valid.
- mul_ready_in, out, 1: downstream-ready to the multiplier.
- mul_result, in, WIDTH: multiplier result.
- inflight, out, $clog2(MAX_INFLIGHT)+1: current tag FIFO occupancy.
- err_orphan, out, 1: sticky flag, set when a multiplier result arrives while the tag FIFO is empty.

## Operation
- **State.** The block holds the round-robin pointer rr_ptr (0..NREQ-1), the tag FIFO (entries of $clog2(NREQ) bits, with read/write pointers and a count), and err_orphan.
- **Grant.** The grant goes to the first requester i with req_valid[i], searching from rr_ptr upward and wrapping modulo NREQ. The grant is combinational from req_valid and rr_ptr.
- **Issue path.**
  - can_issue = mul_ready_out && !fifo_full.
  - mul_valid_in = can_issue && any req_valid.
  - mul_a/mul_b = the granted requester's operands; they are 0 when there is no grant.
  - req_ready[g] = can_issue for granted g only.
  - Issue event: mul_valid_in && mul_ready_out. On issue, push g into the FIFO and set rr_ptr ← (g+1) mod NREQ.
  - With no issue, rr_ptr holds. An ungranted or stalled requester keeps its operands stable (standard valid/ready).
- **Return path.**
  - head = FIFO read entry.
  - When the FIFO is not empty: rsp_valid[head] = mul_valid_out, mul_ready_in = rsp_ready[head], rsp_result = mul_result.
  - When the FIFO is empty: rsp_valid = 0 and mul_ready_in = 1, so the multiplier drains. mul_valid_out in this state sets err_orphan, and the result is dropped.
  - Return event: mul_valid_out && mul_ready_in && !fifo_empty. On a return, pop the FIFO.
- **Ordering.** Results return strictly in issue order. The multiplier must be in-order.
- **Simultaneous push and pop.** Both occur and the count is unchanged.
- **Full FIFO.** A full FIFO blocks issue even if a pop occurs in the same cycle; there is no bypass. This keeps the ready path free of the response path.
- **Wrap-around.** The FIFO pointers wrap modulo MAX_INFLIGHT.
- **Reset.** Reset is asynchronous and may occur mid-operation. It clears rr_ptr to 0, empties the FIFO, and clears err_orphan. In-flight multiplier operations are abandoned; the multiplier must be reset together with this block.
- **Reset values of outputs.** req_ready=0, rsp_valid=0, mul_valid_in=0, mul_a=mul_b=0, rsp_result follows mul_result, mul_ready_in=1, inflight=0, err_orphan=0.

## Timing
- Request to multiplier: 0 cycles (combinational). Result to requester: 0 cycles (combinational).
- End-to-end latency = multiplier latency plus any backpressure stalls.
- Throughput: one issue per cycle while the FIFO is not full and mul_ready_out is high.
- MAX_INFLIGHT ≥ multiplier latency + 1 is required for full throughput.
- rr_ptr, FIFO and err_orphan update on the rising clk edge. inflight is registered occupancy.
- Under rsp_ready[head]=0 the multiplier stalls via mul_ready_in=0. Issue continues until the FIFO or the multiplier fills.

## Test plan
- **Fairness.** All 4 requesters hold valid continuously, multiplier latency 3, all ready=1 → grants cycle 0,1,2,3,0,…; each requester receives exactly its own products (a=i+1, b=0x10000 → result i+1 in Q16.16); inflight settles at 3.
- **Sparse requests.** Only requesters 1 and 3 are valid, rr_ptr=0 → grant 1, then 3, then 1; requesters 0 and 2 never see req_ready.
- **Backpressure.** rsp_ready[2]=0 for 10 cycles with requester 2 at the FIFO head → mul_ready_in=0, issue stops once inflight=MAX_INFLIGHT (8), no result is lost or duplicated, and order is preserved on release.
- **Full with pop.** FIFO full with a pop in the same cycle → req_ready stays 0 that cycle, then issue resumes the next cycle; inflight goes 8→7→8.
- **Orphan result.** Inject mul_valid_out with an empty FIFO → err_orphan=1 and stays set, rsp_valid=0.
- **Reset mid-operation.** Assert rst_n=0 with inflight=5 → all outputs take their reset values asynchronously, rr_ptr=0, and after release the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/fx_mul_arbiter.sv
// Round-robin arbiter sharing one in-order pipelined multiplier among NREQ requesters.
// Issued requester indices are held in a tag FIFO so results are steered back in issue order.
package fpga_cfg_pkg;
    parameter int unsigned FP_WIDTH = 32;
endpackage

module fx_mul_arbiter #(
    parameter int unsigned WIDTH        = fpga_cfg_pkg::FP_WIDTH,
    parameter int unsigned NREQ         = 4,
    parameter int unsigned MAX_INFLIGHT = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NREQ-1:0]                  req_valid,
    output logic [NREQ-1:0]                  req_ready,
    input  logic [NREQ*WIDTH-1:0]            req_a,
    input  logic [NREQ*WIDTH-1:0]            req_b,
    output logic [NREQ-1:0]                  rsp_valid,
    input  logic [NREQ-1:0]                  rsp_ready,
    output logic [WIDTH-1:0]                 rsp_result,
    output logic                             mul_valid_in,
    input  logic                             mul_ready_out,
    output logic [WIDTH-1:0]                 mul_a,
    output logic [WIDTH-1:0]                 mul_b,
    input  logic                             mul_valid_out,
    output logic                             mul_ready_in,
    input  logic [WIDTH-1:0]                 mul_result,
    output logic [$clog2(MAX_INFLIGHT):0]    inflight,
    output logic                             err_orphan
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PW = $clog2(MAX_INFLIGHT);
    localparam int unsigned CW = PW + 1;

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] tag_mem_q [MAX_INFLIGHT];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_orphan_q, err_orphan_d;

    logic [IW-1:0] grant_idx;
    logic [IW-1:0] head;
    logic          grant_found;
    logic          fifo_full;
    logic          fifo_empty;
    logic          can_issue;
    logic          op_sel;
    logic          push;
    logic          pop;
    int unsigned   scan_idx;

    assign fifo_full  = (count_q == CW'(MAX_INFLIGHT));
    assign fifo_empty = (count_q == '0);
    assign head       = tag_mem_q[rd_ptr_q];

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = (32'(rr_ptr_q) + k) % NREQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(scan_idx);
            end
        end
    end

    // rst_n gating forces the issue side to its reset values while reset is held.
    assign can_issue    = rst_n && mul_ready_out && !fifo_full;
    assign op_sel       = rst_n && grant_found;
    assign mul_valid_in = can_issue && grant_found;
    assign mul_a        = op_sel ? req_a[32'(grant_idx)*WIDTH +: WIDTH] : '0;
    assign mul_b        = op_sel ? req_b[32'(grant_idx)*WIDTH +: WIDTH] : '0;
    assign push         = mul_valid_in && mul_ready_out;

    always_comb begin
        req_ready = '0;
        if (can_issue && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (!fifo_empty) begin
            rsp_valid[head] = mul_valid_out;
        end
    end

    assign mul_ready_in = fifo_empty ? 1'b1 : rsp_ready[head];
    assign rsp_result   = mul_result;
    assign pop          = mul_valid_out && mul_ready_in && !fifo_empty;

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        err_orphan_d = err_orphan_q | (mul_valid_out && fifo_empty);
        if (push) begin
            rr_ptr_d = (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IW'(1);
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    // Tag storage needs no reset: entries are only read while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= grant_idx;
        end
    end

    assign inflight   = count_q;
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_fx_mul_arbiter.sv
// Randomized bench for fx_mul_arbiter against a queue-based model of issue order,
// round-robin grants and in-order result return through a latency-3 multiplier model.
module tb_fx_mul_arbiter;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int MI  = 8;
    localparam int LAT = 3;
    localparam int CAP = 16;
    localparam int CW  = $clog2(MI) + 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0]   rsp_result, mul_a, mul_b, mul_result;
    logic           mul_valid_in, mul_ready_out, mul_valid_out, mul_ready_in;
    logic           err_orphan;
    logic [CW-1:0]  inflight;

    always #5 clk = ~clk;

    fx_mul_arbiter #(.WIDTH(W), .NREQ(N), .MAX_INFLIGHT(MI)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .mul_valid_in(mul_valid_in), .mul_ready_out(mul_ready_out),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_valid_out(mul_valid_out), .mul_ready_in(mul_ready_in), .mul_result(mul_result),
        .inflight(inflight), .err_orphan(err_orphan)
    );

    typedef struct { int idx; logic [W-1:0] res; } tag_t;
    typedef struct { int t;   logic [W-1:0] d;   } op_t;

    tag_t         exp_q[$];
    op_t          mul_q[$];
    logic [W-1:0] ra[N], rb[N];
    int           ptr, cyc;
    bit           m_err;
    int           pend_g;
    bit           pend_ret, pend_acc, pend_drain;
    logic [W-1:0] pend_a, pend_b;
    int           p_valid, p_rsp, p_mul;
    logic [N-1:0] vmask, rsp_hold;
    bit           inject;
    int           n_tests = 0, n_fail = 0;
    int           full_seen, full_pop_seen;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = ra[i];
            req_b[i*W +: W] = rb[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Q16.16 product, truncated to the operand width.
    function automatic logic [W-1:0] qmul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'(signed'(a)) * longint'(signed'(b));
        return W'(p >>> 16);
    endfunction

    function automatic bit roll(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic apply_pending();
        if (pend_ret) void'(exp_q.pop_front());
        if (pend_g >= 0) begin
            exp_q.push_back('{pend_g, qmul(ra[pend_g], rb[pend_g])});
            ptr = (pend_g + 1) % N;
            req_valid[pend_g] = 1'b0;
        end
        if (pend_drain) void'(mul_q.pop_front());
        if (pend_acc) mul_q.push_back('{cyc, qmul(pend_a, pend_b)});
        cyc++;
    endtask

    task automatic drive_check();
        int g, idx;
        bit can, full, ret, exp_mri;
        logic [N-1:0] exp_rdy, exp_rsp;
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && vmask[i] && roll(p_valid)) begin
                req_valid[i] = 1'b1;
                ra[i] = $urandom;
                rb[i] = $urandom;
            end
            rsp_ready[i] = !rsp_hold[i] && roll(p_rsp);
        end
        mul_ready_out = (mul_q.size() < CAP) && roll(p_mul);
        mul_valid_out = inject || (mul_q.size() > 0 && cyc - mul_q[0].t >= LAT);
        mul_result    = inject ? W'($urandom) : (mul_q.size() > 0 ? mul_q[0].d : '0);
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        full    = exp_q.size() == MI;
        can     = mul_ready_out && !full;
        exp_rdy = '0;
        if (can && g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("mul_valid_in", 64'(mul_valid_in), 64'(can && g >= 0));
        check("mul_a", 64'(mul_a), 64'(g >= 0 ? ra[g] : '0));
        check("mul_b", 64'(mul_b), 64'(g >= 0 ? rb[g] : '0));
        check("inflight", 64'(inflight), 64'(exp_q.size()));
        exp_rsp = '0;
        exp_mri = 1'b1;
        if (exp_q.size() > 0) begin
            exp_mri = rsp_ready[exp_q[0].idx];
            if (mul_valid_out) exp_rsp[exp_q[0].idx] = 1'b1;
        end
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
        check("mul_ready_in", 64'(mul_ready_in), 64'(exp_mri));
        check("err_orphan", 64'(err_orphan), 64'(m_err));
        ret = exp_q.size() > 0 && mul_valid_out && exp_mri;
        if (ret) check("rsp_result", 64'(rsp_result), 64'(exp_q[0].res));
        if (exp_q.size() == 0 && mul_valid_out) m_err = 1'b1;
        if (full) full_seen++;
        if (full && ret) full_pop_seen++;
        pend_g     = (can && g >= 0) ? g : -1;
        pend_ret   = ret;
        pend_drain = mul_valid_out && mul_ready_in && !inject;
        pend_acc   = mul_valid_in && mul_ready_out;
        pend_a     = mul_a;
        pend_b     = mul_b;
    endtask

    task automatic step();
        @(negedge clk);
        apply_pending();
        drive_check();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".req_ready"}, 64'(req_ready), 64'(0));
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, ".mul_valid_in"}, 64'(mul_valid_in), 64'(0));
        check({tag, ".mul_a"}, 64'(mul_a), 64'(0));
        check({tag, ".mul_b"}, 64'(mul_b), 64'(0));
        check({tag, ".mul_ready_in"}, 64'(mul_ready_in), 64'(1));
        check({tag, ".inflight"}, 64'(inflight), 64'(0));
        check({tag, ".err_orphan"}, 64'(err_orphan), 64'(0));
        check({tag, ".rsp_result"}, 64'(rsp_result), 64'(mul_result));
    endtask

    // Asserts reset between clock edges, checks outputs, then releases at a negedge.
    task automatic do_reset(input string tag, input bit keep_valid);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs(tag);
        exp_q.delete();
        mul_q.delete();
        ptr = 0;
        m_err = 1'b0;
        pend_g = -1;
        pend_ret = 1'b0;
        pend_acc = 1'b0;
        pend_drain = 1'b0;
        inject = 1'b0;
        if (!keep_valid) req_valid = '0;
        mul_valid_out = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_check();
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        mul_ready_out = 1'b0;
        mul_valid_out = 1'b0;
        mul_result = '0;
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            rb[i] = '0;
        end
        ptr = 0; cyc = 0; m_err = 1'b0; inject = 1'b0;
        pend_g = -1; pend_ret = 1'b0; pend_acc = 1'b0; pend_drain = 1'b0;
        pend_a = '0; pend_b = '0;
        full_seen = 0; full_pop_seen = 0;
        vmask = '1; rsp_hold = '0;
        p_valid = 100; p_rsp = 100; p_mul = 100;

        // Fairness: everyone valid, no backpressure.
        do_reset("reset0", 1'b0);
        repeat (40) step();
        check("fair_inflight", 64'(inflight), 64'(3));

        // Sparse: only requesters 1 and 3.
        vmask = 4'b1010;
        do_reset("reset_sparse", 1'b0);
        repeat (30) step();

        // Backpressure on requester 2, then release into a full FIFO.
        vmask = '1;
        full_seen = 0; full_pop_seen = 0;
        do_reset("reset_bp", 1'b0);
        rsp_hold = 4'b0100;
        repeat (20) step();
        check("bp_full_reached", 64'(full_seen > 0), 64'(1));
        check("bp_inflight_max", 64'(inflight), 64'(MI));
        rsp_hold = '0;
        repeat (30) step();
        check("full_with_pop", 64'(full_pop_seen > 0), 64'(1));

        // Randomized traffic.
        p_valid = 60; p_rsp = 70; p_mul = 80;
        for (int r = 0; r < 2000; r++) begin
            if (r % 100 == 0) rsp_hold = 4'($urandom) & 4'($urandom);
            if (r % 100 == 20) rsp_hold = '0;
            step();
        end
        rsp_hold = '0;

        // Orphan result on an empty FIFO.
        vmask = '0; p_rsp = 100; p_mul = 100;
        for (int r = 0; r < 300; r++) begin
            if (exp_q.size() == 0 && mul_q.size() == 0 && req_valid == '0) break;
            step();
        end
        check("drained", 64'(exp_q.size() == 0 && mul_q.size() == 0 && req_valid == '0), 64'(1));
        inject = 1'b1;
        step();
        inject = 1'b0;
        repeat (4) step();
        check("orphan_sticky", 64'(err_orphan), 64'(1));

        // Reset in the middle of traffic with five operations in flight.
        vmask = '1; p_valid = 100; p_rsp = 0; p_mul = 100;
        do_reset("reset_pre", 1'b0);
        for (int r = 0; r < 50; r++) begin
            if (exp_q.size() == 5) break;
            step();
        end
        check("pre_reset_inflight", 64'(inflight), 64'(5));
        do_reset("reset_mid", 1'b1);
        check("first_grant_after_reset", 64'(req_ready), 64'(4'b0001));
        p_rsp = 100;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
